// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types: RAM handshake states, arbiter grant
// states and the machine word.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STREAK_W = 4;
    localparam int unsigned TIMER_W  = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// One registered grant drives the RAM strobes; data requests win unless the
// fetch has been starved for DATA_STREAK_MAX consecutive data grants. A grant
// that sees no ACCESS within TIMEOUT cycles, or sees ERROR, is aborted and
// flags the sticky err bit.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DATA_STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_SAT   = {STREAK_W{1'b1}};
    localparam logic [TIMER_W-1:0]  TIMER_LAST   = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  TIMER_SAT    = {TIMER_W{1'b1}};

    arb_state_t            r_state;
    logic [STREAK_W-1:0]   r_streak;
    logic [TIMER_W-1:0]    r_timer;
    logic                  r_err;

    arb_state_t            w_next_state;
    logic                  w_err_set;
    logic                  w_dreq;
    logic                  w_access;
    logic                  w_req_active;
    logic                  w_fetch_starved;

    assign w_dreq          = dREN | dWEN;
    assign w_access        = (ramstate == ACCESS);
    // Streak beyond the limit (data-only traffic) must also yield to a fetch.
    assign w_fetch_starved = iREN & (r_streak >= STREAK_LIMIT);
    assign w_req_active    = ((r_state == IGNT) & iREN) | ((r_state == DGNT) & w_dreq);

    // Next grant and abort decision.
    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq && !w_fetch_starved) begin
                    w_next_state = DGNT;
                end else if (iREN) begin
                    w_next_state = IGNT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            IGNT, DGNT: begin
                if (!w_req_active) begin
                    // Requester withdrew: drop the grant silently.
                    w_next_state = IDLE;
                end else if (w_access) begin
                    w_next_state = IDLE;
                end else if (ramstate == ERROR) begin
                    w_next_state = IDLE;
                    w_err_set    = 1'b1;
                end else if (r_timer == TIMER_LAST) begin
                    w_next_state = IDLE;
                    w_err_set    = 1'b1;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Grant register and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= r_err | w_err_set;
        end
    end

    // Consecutive data-grant streak, updated only when arbitrating.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_streak <= {STREAK_W{1'b0}};
        end else if (r_state == IDLE) begin
            if (w_next_state == DGNT) begin
                r_streak <= (r_streak == STREAK_SAT) ? r_streak : r_streak + 4'd1;
            end else begin
                r_streak <= {STREAK_W{1'b0}};
            end
        end else begin
            r_streak <= r_streak;
        end
    end

    // Grant timeout counter: zero while idle, counts granted cycles without ACCESS.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer <= {TIMER_W{1'b0}};
        end else if (r_state == IDLE) begin
            r_timer <= {TIMER_W{1'b0}};
        end else if (w_req_active && !w_access && (r_timer != TIMER_SAT)) begin
            r_timer <= r_timer + 8'd1;
        end else begin
            r_timer <= r_timer;
        end
    end

    // RAM strobes follow the grant and drop as soon as the request is withdrawn.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0000_0000;
        ramstore = 32'h0000_0000;
        case (r_state)
            IGNT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                end else begin
                    ramREN  = 1'b0;
                end
            end
            DGNT: begin
                if (w_dreq) begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    // A simultaneous write suppresses the read.
                    ramREN   = dREN & ~dWEN;
                end else begin
                    ramREN   = 1'b0;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign iwait = iREN & ~((r_state == IGNT) & w_access);
    assign dwait = w_dreq & ~((r_state == DGNT) & w_access);
    assign iload = ramload;
    assign dload = ramload;
    assign err   = r_err;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a cycle-by-cycle vector table for the
// basic fetch/data/priority cases, then hand sequences for streak limit,
// timeout, reset mid-access and request withdrawal.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN, err;
    word_t     iload, dload, ramaddr, ramstore;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(.DATA_STREAK_MAX(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    typedef struct {
        logic      rst, iren, dren, dwen;
        word_t     iaddr, daddr, dstore;
        ramstate_t rs;
        word_t     rload;
        logic      e_iwait, e_dwait, e_ren, e_wen;
        word_t     e_addr, e_store;
        logic      e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic iren, input logic dren,
                                input logic dwen, input word_t ia, input word_t da,
                                input word_t ds, input ramstate_t rs, input word_t rl,
                                input logic eiw, input logic edw, input logic eren,
                                input logic ewen, input word_t eaddr, input word_t estore,
                                input logic eerr);
        vec_t v;
        v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen;
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.rs = rs; v.rload = rl;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_ren = eren; v.e_wen = ewen;
        v.e_addr = eaddr; v.e_store = estore; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic drive(input logic rst, input logic iren, input logic dren, input logic dwen,
                         input word_t ia, input word_t da, input word_t ds,
                         input ramstate_t rs, input word_t rl);
        @(negedge CLK);
        RST = rst; iREN = iren; dREN = dren; dWEN = dwen;
        iaddr = ia; daddr = da; dstore = ds; ramstate = rs; ramload = rl;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        string   kinds;
        string   exp_kinds;
        word_t   cur_daddr;
        int      n_done;
        logic [2:0] flags;

        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        ramstate = FREE; ramload = 32'h0;
        repeat (2) @(posedge CLK);

        // rst iren dren dwen iaddr daddr dstore rs rload | iwait dwait ren wen addr store err
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'h40,32'h0,32'h0,FREE,32'h11,   1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h40,32'h0,32'h0,FREE,32'h0,    1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h40,32'h0,32'h0,BUSY,32'h0,    1'b1,1'b0,1'b1,1'b0,32'h40,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h40,32'h0,32'h0,ACCESS,32'h8C010004, 1'b0,1'b0,1'b1,1'b0,32'h40,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h40,32'h0,32'h0,FREE,32'h0,    1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h200,32'h100,32'h0,FREE,32'h0, 1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h200,32'h100,32'h0,BUSY,32'h0, 1'b1,1'b1,1'b1,1'b0,32'h100,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h200,32'h100,32'h0,ACCESS,32'hDEADBEEF, 1'b1,1'b0,1'b1,1'b0,32'h100,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h200,32'h100,32'h0,FREE,32'h0, 1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h200,32'h100,32'h0,ACCESS,32'h12345678, 1'b0,1'b0,1'b1,1'b0,32'h200,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,FREE,32'h0,     1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h0,32'h80,32'hCAFEF00D,FREE,32'h0,   1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h0,32'h80,32'hCAFEF00D,ACCESS,32'h0, 1'b0,1'b0,1'b0,1'b1,32'h80,32'hCAFEF00D,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,FREE,32'h0,     1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].iaddr,
                  vecs[i].daddr, vecs[i].dstore, vecs[i].rs, vecs[i].rload);
            chk($sformatf("v%0d.iwait", i),    iwait,    vecs[i].e_iwait);
            chk($sformatf("v%0d.dwait", i),    dwait,    vecs[i].e_dwait);
            chk($sformatf("v%0d.ramREN", i),   ramREN,   vecs[i].e_ren);
            chk($sformatf("v%0d.ramWEN", i),   ramWEN,   vecs[i].e_wen);
            chk($sformatf("v%0d.ramaddr", i),  ramaddr,  vecs[i].e_addr);
            chk($sformatf("v%0d.ramstore", i), ramstore, vecs[i].e_store);
            chk($sformatf("v%0d.iload", i),    iload,    vecs[i].rload);
            chk($sformatf("v%0d.dload", i),    dload,    vecs[i].rload);
            chk($sformatf("v%0d.err", i),      err,      vecs[i].e_err);
        end

        // Streak limit: writes and fetch both held, RAM always ready.
        kinds     = "";
        exp_kinds = "DDDDID";
        cur_daddr = 32'h1000;
        n_done    = 0;
        for (int c = 0; c < 40 && n_done < 6; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, cur_daddr, 32'hA5A5_0000 + cur_daddr,
                  ACCESS, 32'h0);
            if (ramWEN && !dwait) begin
                chk($sformatf("streak.waddr%0d", n_done), ramaddr, cur_daddr);
                kinds     = {kinds, "D"};
                cur_daddr = cur_daddr + 32'd4;
                n_done++;
            end else if (ramREN && !iwait) begin
                chk($sformatf("streak.faddr%0d", n_done), ramaddr, 32'h300);
                kinds = {kinds, "I"};
                n_done++;
            end
        end
        checks++;
        if (kinds != exp_kinds) begin
            failures++;
            $display("FAIL streak.order actual=%s expected=%s", kinds, exp_kinds);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);

        // Timeout: RAM stays BUSY on a data read grant.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h0, BUSY, 32'h0);
        chk("tmo.arb_ren", ramREN, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h0, BUSY, 32'h0);
            flags = {err, ramREN, dwait};
            chk($sformatf("tmo.granted%0d{err,ren,dwait}", k), flags, 3'b011);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h0, BUSY, 32'h0);
        flags = {err, ramREN, dwait};
        chk("tmo.aborted{err,ren,dwait}", flags, 3'b101);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h0, BUSY, 32'h0);
        flags = {err, ramREN, dwait};
        chk("tmo.regrant{err,ren,dwait}", flags, 3'b111);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, BUSY, 32'h0);
        chk("tmo.err_sticky", err, 1'b1);

        // Reset in the middle of a data write grant.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h600, 32'h77, BUSY, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h600, 32'h77, BUSY, 32'h0);
        chk("rst.pre_wen", ramWEN, 1'b1);
        chk("rst.pre_err", err, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h600, 32'h77, FREE, 32'h0);
        chk("rst.wen", ramWEN, 1'b0);
        chk("rst.addr", ramaddr, 32'h0);
        chk("rst.store", ramstore, 32'h0);
        chk("rst.err", err, 1'b0);
        chk("rst.dwait_raw", dwait, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h600, 32'h77, ACCESS, 32'h0);
        chk("rst.fresh_wen", ramWEN, 1'b1);
        chk("rst.fresh_addr", ramaddr, 32'h600);
        chk("rst.fresh_dwait", dwait, 1'b0);

        // Data read withdrawn on its second granted cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h700, 32'h0, BUSY, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h700, 32'h0, BUSY, 32'h0);
        chk("wd.granted_ren", ramREN, 1'b1);
        chk("wd.granted_dwait", dwait, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h700, 32'h0, BUSY, 32'h0);
        chk("wd.drop_ren", ramREN, 1'b0);
        chk("wd.drop_addr", ramaddr, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h700, 32'h0, BUSY, 32'h0);
        chk("wd.idle_ren", ramREN, 1'b0);
        chk("wd.idle_dwait", dwait, 1'b1);
        chk("wd.err", err, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h700, 32'h0, BUSY, 32'h0);
        chk("wd.regrant_ren", ramREN, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
